// File: rtl/data_mem_responder_if.sv
// Load/store memory bus between the core (master) and the data memory responder (slave).
interface data_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word RAM responder with programmable access latency.
// Optional misaligned-access error reporting: define DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_responder_if.slave bus
);
    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_wr;
    logic              misaligned;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic err_q, err_d;
    assign misaligned   = mis_q;
    assign bus.resp_err = err_q;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];
    assign misaligned      = 1'b0;
    assign bus.resp_err    = 1'b0;
`endif

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        mem_wr       = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        mis_d        = mis_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    idx_d       = bus.req_addr[ADDR_W-1:2];
                    wdata_d     = bus.req_wdata;
                    be_d        = bus.req_be;
                    req_ready_d = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    mis_d       = (bus.req_addr[1:0] != 2'b00);
`endif
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                if (we_q) begin
                    rdata_d = '0;
                    mem_wr  = !misaligned;
                end else begin
                    rdata_d = misaligned ? '0 : mem[idx_q];
                end
`ifdef DATA_MEM_ALIGN_CHECK_EN
                err_d = mis_q;
`endif
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            mis_q        <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            mis_q        <= mis_d;
            err_q        <= err_d;
`endif
        end
    end

    // RAM is deliberately outside the reset domain; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the processor's load/store memory interface: accepts one word read or write request through a valid/ready handshake and returns one response through a valid/ready handshake.
- Holds a word-addressed data RAM and services exactly one outstanding transaction at a time.
- Applies a programmable access latency so the core's LW/SW paths can be exercised against a non-zero-wait memory.
- Sits between the RV32I core's load/store unit and data storage; the core is the initiator.

Parameters:
- DATA_W, 32, data word width; must be 32 (four byte lanes).
- ADDR_W, 12, byte-address width; RAM depth is 2^(ADDR_W-2) words.
- LATENCY, 1, wait cycles between request acceptance and RAM access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write (SW), 0 = read (LW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  4  byte enables for writes; bit i covers wdata[8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  DATA_W  read data.
- resp_err  out  1  transaction failed; only meaningful with ALIGN_CHECK_EN.

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/be. Go to WAIT if LATENCY>0, else ACCESS.
  - WAIT: req_ready=0. Counter counts LATENCY-1 down to 0, then go to ACCESS.
  - ACCESS: one cycle, req_ready=0.
    - Read: resp_rdata <= RAM[addr[ADDR_W-1:2]].
    - Write: each enabled byte lane written; resp_rdata <= 0.
    - Next state RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err held stable until resp_valid&&resp_ready, then go to IDLE with resp_valid=0.
- Latency: acceptance at cycle T -> resp_valid first high at T+LATENCY+2. With LATENCY=0 this is T+2.
- Back-to-back: earliest next acceptance is the cycle after the response handshake. req_ready and resp_valid are never both 1.
- Read ignores req_be and always returns the full word.
- Write with req_be=0: RAM unchanged; response still issued.
- Read-after-write to the same address returns the new data, since the write commits in ACCESS before any later acceptance.
- Inputs are sampled only on the acceptance edge; changes on req_* while busy are ignored.
- Reset mid-transaction: the transaction is dropped. A write commits only if its ACCESS edge completed before rst_n fell. No response is issued after reset.
- Address wrap: none needed; every ADDR_W address maps into the RAM.
- resp_ready held low: the responder stalls in RESP indefinitely with outputs stable.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0]!=0 is still accepted and still takes the full latency. At ACCESS, a misaligned write does not touch RAM and a misaligned read returns resp_rdata=0. The response carries resp_err=1; aligned requests respond with resp_err=0.
- Undefined: req_addr[1:0] is ignored (word index only) and resp_err is tied to 0.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- LATENCY=1: write addr 0x010, data 0xDEADBEEF, be=4'hF. Then read 0x010 -> read resp_valid at T+3, resp_rdata=0xDEADBEEF.
- Byte lanes: word 0x020 = 0x11223344. Write 0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD.
- Backpressure: read response with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0. Raise resp_ready -> next cycle req_ready=1.
- Reset mid-op: LATENCY=4, write 0x12345678 to 0x040 (old 0x0), assert rst_n in WAIT -> no response; later read of 0x040 returns 0x0.
- With DATA_MEM_ALIGN_CHECK_EN: write to 0x013 -> resp_err=1, RAM word 0x010 unchanged. Without the macro, the same write updates word 0x010 and resp_err=0.
